// File: rtl/ddr_seq_pkg.sv
// Shared definitions for the DDR local-interface burst sequencer:
// FSM state encoding, burst-size limits and burst length helpers.
package ddr_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR      = 3'd1,
      ST_RD_REQ  = 3'd2,
      ST_RD_DATA = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // Largest burst is 2^6 = 64 words; local_size is 7 bits wide to hold 64.
   localparam int MAX_BUF_WIDTH = 6;
   localparam int OFS_W         = 7;

   // Buffer widths above the maximum are clamped rather than rejected.
   function automatic logic [2:0] clamp_bw(input logic [3:0] bw);
      return (bw > 4'(MAX_BUF_WIDTH)) ? 3'(MAX_BUF_WIDTH) : bw[2:0];
   endfunction

   // Burst length in words for an already-clamped buffer width.
   function automatic logic [OFS_W-1:0] len_of(input logic [2:0] bw_c);
      return OFS_W'(1) << bw_c;
   endfunction

endpackage

// File: rtl/ddr_local_burst_seq_if.sv
// Buffer-side port of the burst sequencer (arbiter <-> sequencer).
// Signal suffixes are from the sequencer's point of view.
interface ddr_local_burst_seq_if;
   logic        acc_i;
   logic        we_i;
   logic [31:0] adr_i;
   logic [3:0]  buf_width_i;
   logic [3:0]  sel_i;
   logic [31:0] dat_i;
   logic [31:0] adr_o;
   logic [31:0] dat_o;
   logic        ack_o;
   logic        idle_o;
   logic        err_o;

   // Arbiter side: posts accesses and supplies/consumes buffer words.
   modport master (
      output acc_i, we_i, adr_i, buf_width_i, sel_i, dat_i,
      input  adr_o, dat_o, ack_o, idle_o, err_o
   );

   // Sequencer side.
   modport slave (
      input  acc_i, we_i, adr_i, buf_width_i, sel_i, dat_i,
      output adr_o, dat_o, ack_o, idle_o, err_o
   );
endinterface

// File: rtl/ddr_seq_beat_cnt.sv
// Word offset counter within a burst plus last-beat detection.
// The offset saturates on the last beat so it never wraps mid-burst.
module ddr_seq_beat_cnt
   import ddr_seq_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [OFS_W-1:0] len_i,
   output logic [OFS_W-1:0] ofs_o,
   output logic             last_o
);

   logic [OFS_W-1:0] ofs_q;
   logic [OFS_W-1:0] ofs_d;

   assign ofs_o  = ofs_q;
   assign last_o = (ofs_q == (len_i - OFS_W'(1)));

   // Next offset: clear between bursts, step on every transferred beat.
   always_comb begin
      ofs_d = ofs_q;
      if (clr_i) begin
         ofs_d = '0;
      end else if (inc_i && !last_o) begin
         ofs_d = ofs_q + OFS_W'(1);
      end
   end

   // Offset register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         ofs_q <= '0;
      end else begin
         ofs_q <= ofs_d;
      end
   end

endmodule

// File: rtl/ddr_local_burst_seq.sv
// Burst sequencer between the Wishbone arbiter buffer and the Altera DDR
// local (HPC) interface. One buffer-sized access becomes one local burst.
// Optional read timeout: define DDR_SEQ_RD_TIMEOUT_EN.
module ddr_local_burst_seq
   import ddr_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = 25,
   parameter int RD_TIMEOUT = 255
)(
   input  logic                  local_clk_i,
   input  logic                  local_reset_n_i,
   ddr_local_burst_seq_if.slave  bus,
   output logic [ADDR_WIDTH-3:0] local_address_o,
   output logic                  local_write_req_o,
   output logic                  local_read_req_o,
   output logic                  local_burstbegin_o,
   output logic [31:0]           local_wdata_o,
   output logic [3:0]            local_be_o,
   output logic [OFS_W-1:0]      local_size_o,
   input  logic [31:0]           local_rdata_i,
   input  logic                  local_rdata_valid_i,
   input  logic                  local_ready_i
);

   localparam int AW = ADDR_WIDTH - 2;

   state_e           state_q;
   state_e           state_d;
   logic [OFS_W-1:0] len_q;
   logic [AW-1:0]    base_q;
   logic [3:0]       be_q;
   logic             rd_ack_q;
   logic [31:0]      dat_q;
   logic [31:0]      adr_q;

   logic [OFS_W-1:0] len_d;
   logic [AW-1:0]    len_ext;
   logic [AW-1:0]    base_d;
   logic [OFS_W-1:0] ofs;
   logic             last;
   logic             wr_beat;
   logic             rd_beat;
   logic             tmo_hit;
   logic [31:0]      adr_live;
   logic             unused_adr;

   // Burst geometry captured when an access is accepted.
   assign len_d   = len_of(clamp_bw(bus.buf_width_i));
   assign len_ext = AW'(len_d);
   assign base_d  = bus.adr_i[ADDR_WIDTH-1:2] & ~(len_ext - AW'(1));
   assign unused_adr = ^{bus.adr_i[31:ADDR_WIDTH], bus.adr_i[1:0]};

   assign wr_beat  = (state_q == ST_WR) && local_ready_i;
   assign rd_beat  = (state_q == ST_RD_DATA) && local_rdata_valid_i;
   assign adr_live = 32'({(base_q | AW'(ofs)), 2'b00});

   ddr_seq_beat_cnt u_beat_cnt (
      .clk_i   (local_clk_i),
      .rst_n_i (local_reset_n_i),
      .clr_i   (state_q == ST_IDLE),
      .inc_i   (wr_beat || rd_beat),
      .len_i   (len_q),
      .ofs_o   (ofs),
      .last_o  (last)
   );

`ifdef DDR_SEQ_RD_TIMEOUT_EN
   logic [7:0] tmo_q;
   logic [7:0] tmo_d;
   logic       err_q;

   assign tmo_hit = (state_q == ST_RD_DATA) && !local_rdata_valid_i &&
                    (tmo_q == 8'(RD_TIMEOUT - 1));

   // Silence counter: counts RD_DATA cycles since the last valid beat.
   always_comb begin
      tmo_d = '0;
      if (state_q == ST_RD_DATA && !local_rdata_valid_i) begin
         tmo_d = tmo_q + 8'd1;
      end
   end

   // Timeout counter and one-cycle error pulse.
   always_ff @(posedge local_clk_i) begin
      if (!local_reset_n_i) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= tmo_hit;
      end
   end

   assign bus.err_o = err_q;
`else
   logic unused_tmo;
   assign unused_tmo = ^8'(RD_TIMEOUT);
   assign tmo_hit    = 1'b0;
   assign bus.err_o  = 1'b0;
`endif

   // Next-state logic and local-interface request strobes.
   always_comb begin
      state_d            = state_q;
      local_write_req_o  = 1'b0;
      local_read_req_o   = 1'b0;
      local_burstbegin_o = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.acc_i) state_d = bus.we_i ? ST_WR : ST_RD_REQ;
         end
         ST_WR: begin
            local_write_req_o  = 1'b1;
            local_burstbegin_o = (ofs == '0);
            if (local_ready_i && last) state_d = ST_DONE;
         end
         ST_RD_REQ: begin
            local_read_req_o   = 1'b1;
            local_burstbegin_o = 1'b1;
            if (local_ready_i) state_d = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            if ((local_rdata_valid_i && last) || tmo_hit) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (!bus.acc_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge local_clk_i) begin
      if (!local_reset_n_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Burst parameters latched at acceptance; read data/address registered per beat.
   always_ff @(posedge local_clk_i) begin
      if (!local_reset_n_i) begin
         len_q    <= '0;
         base_q   <= '0;
         be_q     <= '0;
         rd_ack_q <= 1'b0;
         dat_q    <= '0;
         adr_q    <= '0;
      end else begin
         if (state_q == ST_IDLE && bus.acc_i) begin
            len_q  <= len_d;
            base_q <= base_d;
            be_q   <= bus.we_i ? bus.sel_i : 4'hF;
         end
         rd_ack_q <= rd_beat;
         if (rd_beat) begin
            dat_q <= local_rdata_i;
            adr_q <= adr_live;
         end
      end
   end

   assign local_address_o = base_q;
   assign local_size_o    = len_q;
   assign local_be_o      = be_q;
   assign local_wdata_o   = (state_q == ST_WR) ? bus.dat_i : 32'h0;

   // Writes use the live offset address so the arbiter can present dat_i
   // combinationally; reads report the address registered with the data.
   assign bus.adr_o  = (state_q == ST_WR) ? adr_live : adr_q;
   assign bus.dat_o  = dat_q;
   assign bus.ack_o  = wr_beat || rd_ack_q;
   assign bus.idle_o = (state_q == ST_IDLE);

endmodule
